// File: rtl/fft_chain_if.sv
// fft_chain_if
// Bundles every controller-facing signal of the FFT -> filter -> inverse-FFT
// frame sequencer.
//   master modport : the sequencer (fft_chain_ctrl)
//   slave  modport : the datapath / upstream / downstream side
// Signals:
//   in_valid/in_ready/load_en : sample load handshake and FFT write strobe
//   fft_done/filt_done/ifft_done : level done flags from each stage
//   fft_run/filt_run/ifft_run : stage releases (top level inverts to hold)
//   sample_idx                : current load/unload sample index
//   out_valid/out_ready       : result stream handshake
//   busy/err/frame_cnt        : status
// N and FCW must match the parameters of the attached fft_chain_ctrl.
interface fft_chain_if #(
    parameter int N   = 16,
    parameter int FCW = 8
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic           in_valid;
    logic           in_ready;
    logic           load_en;
    logic           fft_done;
    logic           filt_done;
    logic           ifft_done;
    logic           fft_run;
    logic           filt_run;
    logic           ifft_run;
    logic [IW-1:0]  sample_idx;
    logic           out_valid;
    logic           out_ready;
    logic           busy;
    logic           err;
    logic [FCW-1:0] frame_cnt;

    modport master (
        input  in_valid, fft_done, filt_done, ifft_done, out_ready,
        output in_ready, load_en, fft_run, filt_run, ifft_run,
               sample_idx, out_valid, busy, err, frame_cnt
    );

    modport slave (
        output in_valid, fft_done, filt_done, ifft_done, out_ready,
        input  in_ready, load_en, fft_run, filt_run, ifft_run,
               sample_idx, out_valid, busy, err, frame_cnt
    );
endinterface

// File: rtl/fft_chain_ctrl.sv
// fft_chain_ctrl
// Frame-level sequencer for the FFT -> filter -> inverse-FFT chain. Loads one
// N-sample frame, releases the stages in order, waits for each done, then
// streams N results out. A per-stage watchdog aborts a stuck frame and sets a
// sticky error flag.
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous, active-low
//   bus    : fft_chain_if.master (handshakes, stage run/done, status)
// Optional build macro FFT_CHAIN_BYPASS_EN adds:
//   bypass_filt : input, sampled in FFT_RUN together with fft_done
//   sel_bypass  : output, registered; 1 while a bypassed frame is in flight
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | one-cycle gap, every stage held
// S_LOAD   | accepting N input samples
// S_FFT    | FFT released, waiting for fft_done
// S_FILT   | FFT + filter released, waiting for filt_done
// S_IFFT   | all stages released, waiting for ifft_done
// S_OUT    | streaming N result samples out
module fft_chain_ctrl #(
    parameter int N       = 16,
    parameter int TIMEOUT = 1024,
    parameter int FCW     = 8
) (
    input  logic clk,
    input  logic reset,
`ifdef FFT_CHAIN_BYPASS_EN
    input  logic bypass_filt,
    output logic sel_bypass,
`endif
    fft_chain_if.master bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_FFT  = 3'd2;
    localparam logic [2:0] S_FILT = 3'd3;
    localparam logic [2:0] S_IFFT = 3'd4;
    localparam logic [2:0] S_OUT  = 3'd5;

    logic [2:0]     state_q, state_d;
    logic [IW-1:0]  idx_q;
    logic           idx_inc;
    logic [WW-1:0]  wd_q;
    logic           wd_exp;
    logic           wd_abort;
    logic           run_state;
    logic           frame_end;
    logic [FCW-1:0] fcnt_q;
    logic           err_q;
    logic           idx_last;
    logic           filt_rel;
`ifdef FFT_CHAIN_BYPASS_EN
    logic           take_bypass;
    logic           sel_q;
`endif

    assign idx_last  = (idx_q == IW'(N - 1));
    assign wd_exp    = (wd_q == WW'(TIMEOUT - 1));
    assign run_state = (state_q == S_FFT) || (state_q == S_FILT) || (state_q == S_IFFT);

    always_comb begin
        state_d   = state_q;
        idx_inc   = 1'b0;
        wd_abort  = 1'b0;
        frame_end = 1'b0;
`ifdef FFT_CHAIN_BYPASS_EN
        take_bypass = 1'b0;
`endif
        case (state_q)
            S_IDLE: state_d = S_LOAD;
            S_LOAD: begin
                if (bus.in_valid) begin
                    idx_inc = 1'b1;
                    if (idx_last) state_d = S_FFT;
                end
            end
            // done has priority over an expiring watchdog in every run state
            S_FFT: begin
                if (bus.fft_done) begin
`ifdef FFT_CHAIN_BYPASS_EN
                    if (bypass_filt) begin
                        take_bypass = 1'b1;
                        state_d     = S_IFFT;
                    end else begin
                        state_d = S_FILT;
                    end
`else
                    state_d = S_FILT;
`endif
                end else if (wd_exp) begin
                    wd_abort = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_FILT: begin
                if (bus.filt_done) begin
                    state_d = S_IFFT;
                end else if (wd_exp) begin
                    wd_abort = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_IFFT: begin
                if (bus.ifft_done) begin
                    state_d = S_OUT;
                end else if (wd_exp) begin
                    wd_abort = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    idx_inc = 1'b1;
                    if (idx_last) begin
                        frame_end = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            wd_q    <= '0;
            fcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (idx_inc) idx_q <= idx_q + IW'(1);
            // any state change restarts the watchdog, so each run state starts at 0
            if (state_d != state_q)
                wd_q <= '0;
            else if (run_state)
                wd_q <= wd_q + WW'(1);
            if (frame_end) fcnt_q <= fcnt_q + FCW'(1);
            if (wd_abort)  err_q  <= 1'b1;
        end
    end

`ifdef FFT_CHAIN_BYPASS_EN
    always_ff @(posedge clk) begin
        if (!reset)
            sel_q <= 1'b0;
        else if (take_bypass)
            sel_q <= 1'b1;
        else if (state_d == S_IDLE)
            sel_q <= 1'b0;
    end

    assign sel_bypass = sel_q;
    // a bypassed frame never releases the filter
    assign filt_rel = (state_q == S_FILT) ||
                      (((state_q == S_IFFT) || (state_q == S_OUT)) && !sel_q);
`else
    assign filt_rel = (state_q == S_FILT) || (state_q == S_IFFT) || (state_q == S_OUT);
`endif

    assign bus.in_ready   = (state_q == S_LOAD);
    assign bus.load_en    = bus.in_valid && (state_q == S_LOAD);
    assign bus.fft_run    = (state_q == S_FFT) || (state_q == S_FILT) ||
                            (state_q == S_IFFT) || (state_q == S_OUT);
    assign bus.filt_run   = filt_rel;
    assign bus.ifft_run   = (state_q == S_IFFT) || (state_q == S_OUT);
    assign bus.out_valid  = (state_q == S_OUT);
    assign bus.busy       = run_state || (state_q == S_OUT);
    assign bus.sample_idx = idx_q;
    assign bus.err        = err_q;
    assign bus.frame_cnt  = fcnt_q;
endmodule

// File: tb/tb_fft_chain_ctrl.sv
`timescale 1ns/1ps
module tb_fft_chain_ctrl;
    localparam int N       = 16;
    localparam int TIMEOUT = 64;
    localparam int FCW     = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fft_chain_if #(.N(N), .FCW(FCW)) bus ();

`ifdef FFT_CHAIN_BYPASS_EN
    logic bypass_filt = 1'b0;
    logic sel_bypass;
`endif

    fft_chain_ctrl #(.N(N), .TIMEOUT(TIMEOUT), .FCW(FCW)) dut (
        .clk         (clk),
        .reset       (reset),
`ifdef FFT_CHAIN_BYPASS_EN
        .bypass_filt (bypass_filt),
        .sel_bypass  (sel_bypass),
`endif
        .bus         (bus)
    );

    // stage responder: done rises dly cycles after the stage's run rises
    int dly_fft = 2, dly_filt = 2, dly_ifft = 2;
    int cnt_fft = 0, cnt_filt = 0, cnt_ifft = 0;
    always @(posedge clk) begin
        cnt_fft  <= bus.fft_run  ? cnt_fft  + 1 : 0;
        cnt_filt <= bus.filt_run ? cnt_filt + 1 : 0;
        cnt_ifft <= bus.ifft_run ? cnt_ifft + 1 : 0;
    end
    assign bus.fft_done  = bus.fft_run  && (cnt_fft  >= dly_fft);
    assign bus.filt_done = bus.filt_run && (cnt_filt >= dly_filt);
    assign bus.ifft_done = bus.ifft_run && (cnt_ifft >= dly_ifft);

    int total = 0, bad = 0;
    int r_load, r_fft, r_filt, r_ifft, r_out, r_idle, r_err;
    int n_load, n_out;
    int idx_bad, order_bad, le_bad, sel_bad;
    bit filt_seen;
    bit byp_now = 1'b0;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Runs one frame from the current (IDLE) cycle c=0 until IDLE is seen again.
    // Records the first cycle each output rises. in_valid toggles when tog=1;
    // out_ready drops for st_len OUT cycles starting at OUT cycle st_at;
    // rst_ifft>0 pulls reset low on that IFFT_RUN cycle.
    task automatic run_frame(input bit tog, input int st_at, input int st_len,
                             input int rst_ifft);
        int loads, outs, ocyc, icyc;
        r_load = -1; r_fft = -1; r_filt = -1; r_ifft = -1;
        r_out = -1; r_idle = -1; r_err = -1;
        idx_bad = 0; order_bad = 0; le_bad = 0; sel_bad = 0; filt_seen = 0;
        loads = 0; outs = 0; ocyc = 0; icyc = 0;
        for (int c = 0; c < 400; c++) begin
            if (bus.in_ready  && r_load < 0) r_load = c;
            if (bus.fft_run   && r_fft  < 0) r_fft  = c;
            if (bus.filt_run  && r_filt < 0) r_filt = c;
            if (bus.ifft_run  && r_ifft < 0) r_ifft = c;
            if (bus.out_valid && r_out  < 0) r_out  = c;
            if (bus.err       && r_err  < 0) r_err  = c;
            if (bus.filt_run) filt_seen = 1;
            if ((bus.filt_run || bus.ifft_run || bus.out_valid) && !bus.fft_run) order_bad++;
            if (bus.out_valid && !bus.ifft_run) order_bad++;
            if (bus.busy != bus.fft_run) order_bad++;
            if (!byp_now && bus.ifft_run && !bus.filt_run) order_bad++;
`ifdef FFT_CHAIN_BYPASS_EN
            if (bus.out_valid && (sel_bypass != byp_now)) sel_bad++;
            if (!bus.busy && sel_bypass) sel_bad++;
`endif
            if (c > 0 && !bus.in_ready && !bus.busy) begin
                r_idle = c;
                break;
            end
            bus.in_valid  = tog ? ((c % 2) == 1) : 1'b1;
            bus.out_ready = !(bus.out_valid && ocyc >= st_at && ocyc < st_at + st_len);
            reset = !(rst_ifft > 0 && bus.ifft_run && icyc == rst_ifft - 1);
            #1;
            if (bus.in_ready) begin
                if (int'(bus.sample_idx) != loads) idx_bad++;
                if (bus.load_en != bus.in_valid) le_bad++;
                if (bus.in_valid) loads++;
            end else if (bus.load_en) begin
                le_bad++;
            end
            if (bus.out_valid) begin
                if (int'(bus.sample_idx) != outs) idx_bad++;
                if (bus.out_ready) outs++;
                ocyc++;
            end
            if (bus.ifft_run) icyc++;
            @(posedge clk);
            #1;
            reset = 1'b1;
        end
        n_load = loads;
        n_out  = outs;
    endtask

    task automatic chk_run(input string tag);
        chk({tag, "_idx_seq"}, idx_bad, 0);
        chk({tag, "_order"}, order_bad, 0);
        chk({tag, "_load_en"}, le_bad, 0);
        chk({tag, "_sel"}, sel_bad, 0);
    endtask

    initial begin
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  bus.in_ready, 0);
        chk("rst_load_en",   bus.load_en, 0);
        chk("rst_fft_run",   bus.fft_run, 0);
        chk("rst_filt_run",  bus.filt_run, 0);
        chk("rst_ifft_run",  bus.ifft_run, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy",      bus.busy, 0);
        chk("rst_err",       bus.err, 0);
        chk("rst_frame_cnt", int'(bus.frame_cnt), 0);
        chk("rst_idx",       int'(bus.sample_idx), 0);

        // basic frame, done 2 cycles after each run rises
        run_frame(0, 0, 0, 0);
        chk("t1_load",  r_load, 1);
        chk("t1_fft",   r_fft, 17);
        chk("t1_filt",  r_filt, 20);
        chk("t1_ifft",  r_ifft, 23);
        chk("t1_out",   r_out, 26);
        chk("t1_idle",  r_idle, 42);
        chk("t1_nload", n_load, 16);
        chk("t1_nout",  n_out, 16);
        chk("t1_fcnt",  int'(bus.frame_cnt), 1);
        chk_run("t1");

        // toggling in_valid, 5-cycle out_ready stall; IDLE lasted one cycle
        run_frame(1, 3, 5, 0);
        chk("t2_load",  r_load, 1);
        chk("t2_fft",   r_fft, 32);
        chk("t2_out",   r_out, 41);
        chk("t2_idle",  r_idle, 62);
        chk("t2_nload", n_load, 16);
        chk("t2_nout",  n_out, 16);
        chk("t2_fcnt",  int'(bus.frame_cnt), 2);
        chk_run("t2");

        // filt_done arrives on the 64th FILT_RUN cycle: done beats timeout
        dly_filt = 63;
        run_frame(0, 0, 0, 0);
        chk("t3_filt", r_filt, 20);
        chk("t3_ifft", r_ifft, 84);
        chk("t3_idle", r_idle, 103);
        chk("t3_err",  r_err, -1);
        chk("t3_fcnt", int'(bus.frame_cnt), 3);
        chk_run("t3");

        // filt_done never comes: abort after the 64th FILT_RUN cycle
        dly_filt = 1000;
        run_frame(0, 0, 0, 0);
        chk("t4_ifft",    r_ifft, -1);
        chk("t4_idle",    r_idle, 84);
        chk("t4_err_at",  r_err, 84);
        chk("t4_fft_run", bus.fft_run, 0);
        chk("t4_filt_run", bus.filt_run, 0);
        chk("t4_fcnt",    int'(bus.frame_cnt), 3);
        chk_run("t4");
        dly_filt = 2;
        run_frame(0, 0, 0, 0);
        chk("t4b_idle", r_idle, 42);
        chk("t4b_err",  bus.err, 1);
        chk("t4b_fcnt", int'(bus.frame_cnt), 4);
        chk_run("t4b");

        // reset on the third IFFT_RUN cycle
        dly_ifft = 5;
        run_frame(0, 0, 0, 3);
        chk("t5_ifft",     r_ifft, 23);
        chk("t5_idle",     r_idle, 26);
        chk("t5_fcnt",     int'(bus.frame_cnt), 0);
        chk("t5_err",      bus.err, 0);
        chk("t5_fft_run",  bus.fft_run, 0);
        chk("t5_out_valid", bus.out_valid, 0);
        chk("t5_idx",      int'(bus.sample_idx), 0);
        dly_ifft = 2;
        run_frame(0, 0, 0, 0);
        chk("t5b_idle", r_idle, 42);
        chk("t5b_fcnt", int'(bus.frame_cnt), 1);
        chk("t5b_err",  bus.err, 0);
        chk_run("t5b");

        // done already high on first cycle of each run state: 2N+4 frame
        dly_fft = 0; dly_filt = 0; dly_ifft = 0;
        run_frame(0, 0, 0, 0);
        chk("t6_fft",  r_fft, 17);
        chk("t6_filt", r_filt, 18);
        chk("t6_ifft", r_ifft, 19);
        chk("t6_idle", r_idle, 2 * N + 4);
        chk("t6_fcnt", int'(bus.frame_cnt), 2);
        chk_run("t6");

`ifdef FFT_CHAIN_BYPASS_EN
        // filter bypass: FFT_RUN -> IFFT_RUN, 2N+3 frame
        bypass_filt = 1'b1;
        byp_now = 1'b1;
        run_frame(0, 0, 0, 0);
        chk("t7_filt_seen", filt_seen, 0);
        chk("t7_ifft", r_ifft, 18);
        chk("t7_idle", r_idle, 2 * N + 3);
        chk("t7_sel_idle", sel_bypass, 0);
        chk("t7_fcnt", int'(bus.frame_cnt), 3);
        chk_run("t7");
        bypass_filt = 1'b0;
        byp_now = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
